// File: rtl/wb_daq_pkg.sv
// Shared definitions for the wb_dsp DAQ acquisition channel.
//   DAQ_DATA_WIDTH : default ADC sample width
//   DAQ_FIFO_AW    : default FIFO address bits (depth = 2**AW)
//   DAQ_OUT_WIDTH  : default FIFO word / data_out width
//   drain_state_t  : drain FSM states (IDLE = 0, DRAIN = 1)
package wb_daq_pkg;
    localparam int DAQ_DATA_WIDTH = 8;
    localparam int DAQ_FIFO_AW    = 5;
    localparam int DAQ_OUT_WIDTH  = 32;

    typedef enum logic {
        STATE_IDLE  = 1'b0,
        STATE_DRAIN = 1'b1
    } drain_state_t;
endpackage

// File: rtl/wb_daq_channel_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_push       : write i_data (ignored when full)
//   i_pop        : drop the head word (ignored when empty)
//   i_data       : write data
//   o_data       : head word, zero when empty
//   o_count      : number of stored words (0..2**AW)
//   o_empty      : no words stored
//   o_full       : 2**AW words stored
module wb_daq_channel_fifo
    import wb_daq_pkg::*;
#(
    parameter int WIDTH = DAQ_OUT_WIDTH,
    parameter int AW    = DAQ_FIFO_AW
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic [AW:0]      o_count,
    output logic             o_empty,
    output logic             o_full
);
    localparam int DEPTH = 2**AW;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_count = r_count;

    // Storage carries no reset; stale words are never visible because
    // the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally at AW bits.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];
endmodule

// File: rtl/wb_daq_channel.sv
// One DAQ acquisition channel: captures ADC samples into a FIFO and asks the
// SRAM writer to drain it once a programmed number of samples is buffered.
// Ports:
//   wb_clk, wb_rst               : system clock, asynchronous active-high reset
//   adc_clk                      : unused, kept for interface compatibility
//   master_enable, control[0]    : both high to allow capture
//   fifo_number_samples_terminal : fill level that starts a drain (0 acts as 1)
//   adc_data_out, adc_data_ready : ADC sample and its (possibly long) strobe
//   data_done                    : writer consumed data_out (one pop per rising edge)
//   data_out                     : FIFO head {zero pad, sample}, zero when empty
//   start_sram                   : registered drain request
//   fifo_empty                   : FIFO holds no words
module wb_daq_channel
    import wb_daq_pkg::*;
#(
    parameter int DATA_WIDTH = DAQ_DATA_WIDTH,
    parameter int FIFO_AW    = DAQ_FIFO_AW,
    parameter int OUT_WIDTH  = DAQ_OUT_WIDTH
) (
    input  logic                  wb_clk,
    input  logic                  wb_rst,
    input  logic                  adc_clk,
    input  logic                  master_enable,
    input  logic [31:0]           control,
    input  logic [FIFO_AW-1:0]    fifo_number_samples_terminal,
    input  logic [DATA_WIDTH-1:0] adc_data_out,
    input  logic                  adc_data_ready,
    input  logic                  data_done,
    output logic [OUT_WIDTH-1:0]  data_out,
    output logic                  start_sram,
    output logic                  fifo_empty
);
    logic               r_ready_d;
    logic               r_done_d;
    drain_state_t       r_state;
    logic               r_start;
    logic               w_enable;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [FIFO_AW:0]   w_count;
    logic [FIFO_AW:0]   w_term;
    logic [OUT_WIDTH-1:0] w_fifo_din;
    logic               w_unused;

    // adc_clk and the reserved control bits are intentionally ignored.
    assign w_unused = ^{adc_clk, control[31:1]};

    assign w_enable   = master_enable & control[0];
    assign w_term     = (fifo_number_samples_terminal == '0) ? (FIFO_AW+1)'(1)
                                                             : {1'b0, fifo_number_samples_terminal};
    assign w_fifo_din = {{(OUT_WIDTH-DATA_WIDTH){1'b0}}, adc_data_out};

    // Rising-edge detectors turn multi-cycle strobes into single-cycle events.
    assign w_push = adc_data_ready & ~r_ready_d & w_enable & ~w_full;
    assign w_pop  = data_done & ~r_done_d & ~w_empty;

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            r_ready_d <= 1'b0;
            r_done_d  <= 1'b0;
        end else begin
            r_ready_d <= adc_data_ready;
            r_done_d  <= data_done;
        end
    end

    wb_daq_channel_fifo #(
        .WIDTH (OUT_WIDTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .i_clk   (wb_clk),
        .i_rst   (wb_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_fifo_din),
        .o_data  (data_out),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // Drain FSM. The request stays up until a pop empties the FIFO; a push
    // landing in the same cycle as the last pop keeps the drain going.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            r_state <= STATE_IDLE;
            r_start <= 1'b0;
        end else begin
            case (r_state)
                STATE_IDLE: begin
                    if (w_count >= w_term) begin
                        r_state <= STATE_DRAIN;
                        r_start <= 1'b1;
                    end
                end
                STATE_DRAIN: begin
                    if (w_pop && !w_push && (w_count == (FIFO_AW+1)'(1))) begin
                        r_state <= STATE_IDLE;
                        r_start <= 1'b0;
                    end
                end
                default: begin
                    r_state <= STATE_IDLE;
                    r_start <= 1'b0;
                end
            endcase
        end
    end

    assign start_sram = r_start;
    assign fifo_empty = w_empty;
endmodule

// File: tb/tb_wb_daq_channel.sv
module tb_wb_daq_channel;
    logic        wb_clk = 1'b0;
    logic        wb_rst = 1'b1;
    logic        adc_clk = 1'b0;
    logic        master_enable = 1'b0;
    logic [31:0] control = 32'h0;
    logic [4:0]  fifo_number_samples_terminal = 5'd4;
    logic [7:0]  adc_data_out = 8'h0;
    logic        adc_data_ready = 1'b0;
    logic        data_done = 1'b0;
    logic [31:0] data_out;
    logic        start_sram;
    logic        fifo_empty;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: the FIFO is a queue of samples, the drain request a flag.
    logic [7:0] mq[$];
    bit         m_drain = 1'b0;
    bit         m_prev_rdy = 1'b0;
    bit         m_prev_done = 1'b0;
    int         m_pushes = 0;
    int         m_pops = 0;

    always #5  wb_clk  = ~wb_clk;
    always #20 adc_clk = ~adc_clk;

    wb_daq_channel dut (
        .wb_clk                       (wb_clk),
        .wb_rst                       (wb_rst),
        .adc_clk                      (adc_clk),
        .master_enable                (master_enable),
        .control                      (control),
        .fifo_number_samples_terminal (fifo_number_samples_terminal),
        .adc_data_out                 (adc_data_out),
        .adc_data_ready               (adc_data_ready),
        .data_done                    (data_done),
        .data_out                     (data_out),
        .start_sram                   (start_sram),
        .fifo_empty                   (fifo_empty)
    );

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, required %h", name, $time, act, exp);
        end
    endtask

    // One wb_clk cycle: drive inputs after the falling edge, check outputs
    // against the model, then advance the model over the coming rising edge.
    task automatic step(input logic rdy, input logic [7:0] d, input logic done);
        bit m_push;
        bit m_pop;
        int term;
        @(negedge wb_clk);
        adc_data_ready = rdy;
        adc_data_out   = d;
        data_done      = done;
        #1;
        chk("data_out",   data_out, (mq.size() > 0) ? {24'h0, mq[0]} : 32'h0);
        chk("start_sram", 32'(start_sram), 32'(m_drain));
        chk("fifo_empty", 32'(fifo_empty), 32'(mq.size() == 0));
        m_push = rdy && !m_prev_rdy && master_enable && control[0] && (mq.size() < 32);
        m_pop  = done && !m_prev_done && (mq.size() > 0);
        chk("push_pulse", 32'(dut.w_push), 32'(m_push));
        chk("pop_pulse",  32'(dut.w_pop),  32'(m_pop));
        term = (fifo_number_samples_terminal == 0) ? 1 : int'(fifo_number_samples_terminal);
        if (m_drain) begin
            if (m_pop && !m_push && mq.size() == 1) m_drain = 1'b0;
        end else if (mq.size() >= term) begin
            m_drain = 1'b1;
        end
        if (m_pop) begin
            void'(mq.pop_front());
            m_pops++;
        end
        if (m_push) begin
            mq.push_back(d);
            m_pushes++;
        end
        m_prev_rdy  = rdy;
        m_prev_done = done;
    endtask

    // One ADC sample: strobe high for two cycles, low for two (one adc_clk period).
    task automatic sample(input logic [7:0] d, input bit rand_done);
        for (int k = 0; k < 4; k++) begin
            step((k < 2), d, rand_done && m_drain && ($urandom_range(0, 1) == 1));
        end
    endtask

    task automatic do_reset();
        @(negedge wb_clk);
        #2;
        adc_data_ready = 1'b0;
        data_done      = 1'b0;
        wb_rst         = 1'b1;
        #1;
        chk("rst_data_out",   data_out, 32'h0);
        chk("rst_start_sram", 32'(start_sram), 32'h0);
        chk("rst_fifo_empty", 32'(fifo_empty), 32'h1);
        repeat (2) @(posedge wb_clk);
        @(negedge wb_clk);
        wb_rst = 1'b0;
        mq.delete();
        m_drain     = 1'b0;
        m_prev_rdy  = 1'b0;
        m_prev_done = 1'b0;
    endtask

    initial begin
        logic [7:0] s[4];
        logic [7:0] first;
        int guard;

        // 1: reset held then released, captures blocked while disabled
        repeat (3) @(posedge wb_clk);
        #1;
        chk("init_data_out",   data_out, 32'h0);
        chk("init_start_sram", 32'(start_sram), 32'h0);
        chk("init_fifo_empty", 32'(fifo_empty), 32'h1);
        @(negedge wb_clk);
        wb_rst = 1'b0;
        master_enable = 1'b0; control = 32'h1;
        sample(8'h11, 1'b0);
        master_enable = 1'b1; control = 32'hFFFF_FFFE;
        sample(8'h22, 1'b0);
        chk("disabled_empty", 32'(fifo_empty), 32'h1);

        // 2: four samples with terminal 4
        control = 32'h1;
        fifo_number_samples_terminal = 5'd4;
        for (int i = 0; i < 4; i++) begin
            s[i] = 8'($urandom);
            sample(s[i], 1'b0);
        end
        chk("fill4_start_sram", 32'(start_sram), 32'h1);
        chk("fill4_data_out",   data_out, {24'h0, s[0]});

        // 3: writer acknowledges every other cycle
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h0, 1'b1);
            step(1'b0, 8'h0, 1'b0);
        end
        chk("drain4_empty", 32'(fifo_empty), 32'h1);
        chk("drain4_start", 32'(start_sram), 32'h0);

        // 4: 60 ADC periods of continuous capture with random writer timing
        for (int i = 0; i < 60; i++) sample(8'($urandom), 1'b1);
        guard = 0;
        while (mq.size() > 0 && guard < 400) begin
            step(1'b0, 8'h0, m_drain && !m_prev_done);
            guard++;
        end
        step(1'b0, 8'h0, 1'b0);
        chk("stream_conserved", 32'(m_pops), 32'(m_pushes));

        // 5: fill past full with no acknowledgements
        fifo_number_samples_terminal = 5'd20;
        first = 8'($urandom);
        sample(first, 1'b0);
        for (int i = 1; i < 33; i++) sample(8'($urandom), 1'b0);
        chk("full_count",    32'(dut.u_fifo.o_count), 32'd32);
        chk("full_data_out", data_out, {24'h0, first});
        chk("full_start",    32'(start_sram), 32'h1);

        // 6: simultaneous push and pop in DRAIN, then reset mid-drain
        step(1'b0, 8'h0, 1'b1);
        step(1'b0, 8'h0, 1'b0);
        step(1'b1, 8'($urandom), 1'b1);
        step(1'b0, 8'h0, 1'b0);
        chk("pushpop_count", 32'(dut.u_fifo.o_count), 32'd31);
        chk("pushpop_start", 32'(start_sram), 32'h1);
        do_reset();
        step(1'b0, 8'h0, 1'b0);

        // terminal of zero behaves as one
        fifo_number_samples_terminal = 5'd0;
        for (int i = 0; i < 3; i++) sample(8'($urandom), 1'b1);
        guard = 0;
        while (mq.size() > 0 && guard < 100) begin
            step(1'b0, 8'h0, !m_prev_done);
            guard++;
        end
        step(1'b0, 8'h0, 1'b0);
        step(1'b0, 8'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
